// File: rtl/bit_unstuff_rx.sv
// ---------------------------------------------------------------------------
// bit_unstuff_rx
//
// Receive-side bit unstuffer. It sits between an NRZI decoder and a packet
// receiver. It removes the stuffed zero that follows every run of six ones.
// It flags a run of seven ones as a stuffing violation. It frames each packet
// with one-cycle start/end pulses. All outputs are registered, so each output
// lags the input bit or pulse that caused it by exactly one clock.
//
// Ports
//   clk             in   receive bit clock, one serial bit per cycle
//   rst_n           in   asynchronous active-low reset
//   abort           in   synchronous receive abort; drops the packet silently
//   s_in            in   NRZI-decoded serial bit
//   start_unstuffer in   one-cycle packet-start pulse from the decoder
//   end_unstuffer   in   one-cycle packet-end pulse from the decoder
//   bit_out         out  unstuffed data bit; holds its value while bit_valid=0
//   bit_valid       out  bit_out carries a payload bit this cycle
//   start_pkt       out  one-cycle packet-start pulse to the packet receiver
//   end_pkt         out  one-cycle packet-end pulse to the packet receiver
//   stuff_err       out  one-cycle pulse on seven consecutive ones
// ---------------------------------------------------------------------------
module bit_unstuff_rx (
  input  logic clk,
  input  logic rst_n,
  input  logic abort,
  input  logic s_in,
  input  logic start_unstuffer,
  input  logic end_unstuffer,
  output logic bit_out,
  output logic bit_valid,
  output logic start_pkt,
  output logic end_pkt,
  output logic stuff_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // This many consecutive ones forces the next bit to be a stuffed zero.
  localparam logic [2:0] RUN_MAX = 3'd6;

  state_t     state_q,     state_d;
  logic [2:0] cnt_q,       cnt_d;
  logic       bit_out_q,   bit_out_d;
  logic       bit_valid_q, bit_valid_d;
  logic       start_pkt_q, start_pkt_d;
  logic       end_pkt_q,   end_pkt_d;
  logic       stuff_err_q, stuff_err_d;

  // Next-state, ones counter and next-output decode for the unstuffer FSM.
  always_comb begin
    // Hold state, counter and data bit by default. All pulses default low.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    start_pkt_d = 1'b0;
    end_pkt_d   = 1'b0;
    stuff_err_d = 1'b0;

    if (abort) begin
      // Abort drops the packet with no end_pkt. It also beats a start
      // pulse that arrives in the same cycle.
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Clear the ones history on every visit so that packets stay
          // independent. end_unstuffer is ignored here, so start wins.
          cnt_d = 3'd0;
          if (start_unstuffer) begin
            state_d     = ST_ALIGN;
            start_pkt_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_ALIGN: begin
          // The decoder uses this cycle to settle, so s_in is not data.
          cnt_d = 3'd0;
          if (end_unstuffer) begin
            state_d   = ST_IDLE;
            end_pkt_d = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (end_unstuffer) begin
            // The bit in the end cycle is part of the EOP, not payload.
            state_d   = ST_IDLE;
            cnt_d     = 3'd0;
            end_pkt_d = 1'b1;
          end else if (cnt_q < RUN_MAX) begin
            bit_valid_d = 1'b1;
            bit_out_d   = s_in;
            if (s_in) begin
              cnt_d = cnt_q + 3'd1;
            end else begin
              cnt_d = 3'd0;
            end
          end else if (!s_in) begin
            // Stuffed zero after six ones: consume it silently.
            cnt_d = 3'd0;
          end else begin
            // Seventh consecutive one: a stuffing violation.
            cnt_d       = 3'd0;
            stuff_err_d = 1'b1;
            state_d     = ST_ERR;
          end
        end

        ST_ERR: begin
          // Discard the rest of the packet until the decoder closes it.
          cnt_d = 3'd0;
          if (end_unstuffer) begin
            state_d   = ST_IDLE;
            end_pkt_d = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      start_pkt_q <= 1'b0;
      end_pkt_q   <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      start_pkt_q <= start_pkt_d;
      end_pkt_q   <= end_pkt_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign start_pkt = start_pkt_q;
  assign end_pkt   = end_pkt_q;
  assign stuff_err = stuff_err_q;

endmodule

// File: tb/tb_bit_unstuff_rx.sv
module tb_bit_unstuff_rx;

  logic clk;
  logic rst_n;
  logic abort;
  logic s_in;
  logic start_unstuffer;
  logic end_unstuffer;
  logic bit_out;
  logic bit_valid;
  logic start_pkt;
  logic end_pkt;
  logic stuff_err;

  int errors;
  int checks;

  // Observation accumulators, cleared by each scenario.
  int          n_valid;
  int          n_start;
  int          n_end;
  int          n_err;
  logic [31:0] bits_sh;

  bit_unstuff_rx dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .abort           (abort),
    .s_in            (s_in),
    .start_unstuffer (start_unstuffer),
    .end_unstuffer   (end_unstuffer),
    .bit_out         (bit_out),
    .bit_valid       (bit_valid),
    .start_pkt       (start_pkt),
    .end_pkt         (end_pkt),
    .stuff_err       (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_obs();
    n_valid = 0;
    n_start = 0;
    n_end   = 0;
    n_err   = 0;
    bits_sh = 32'd0;
  endtask

  // Apply one cycle of inputs, then sample the registered outputs 1 time unit
  // after the edge. Payload bits are shifted into bits_sh.
  task automatic drive(input logic s, input logic st, input logic en, input logic ab);
    s_in            = s;
    start_unstuffer = st;
    end_unstuffer   = en;
    abort           = ab;
    @(posedge clk);
    #1;
    if (bit_valid === 1'b1) begin
      n_valid = n_valid + 1;
      bits_sh = {bits_sh[30:0], bit_out};
    end
    if (start_pkt === 1'b1) n_start = n_start + 1;
    if (end_pkt === 1'b1)   n_end   = n_end + 1;
    if (stuff_err === 1'b1) n_err   = n_err + 1;
    s_in            = 1'b0;
    start_unstuffer = 1'b0;
    end_unstuffer   = 1'b0;
    abort           = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_in = 1'b0; start_unstuffer = 1'b0; end_unstuffer = 1'b0; abort = 1'b0;
    #3;
    checks++;
    if ({bit_out, bit_valid, start_pkt, end_pkt, stuff_err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bit_out, bit_valid, start_pkt, end_pkt, stuff_err});
    end
    #9 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (start_pkt !== 1'b1) begin
      errors++; $display("FAIL basic_start_pkt: got %b expected 1", start_pkt);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);  // ALIGN cycle: the bit is ignored
    checks++;
    if (bit_valid !== 1'b0 || start_pkt !== 1'b0) begin
      errors++; $display("FAIL basic_align: valid=%b start=%b expected 0 0", bit_valid, start_pkt);
    end
    for (int i = 7; i >= 0; i--) drive(pat[i], 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (end_pkt !== 1'b1 || bit_valid !== 1'b0) begin
      errors++; $display("FAIL basic_end: end=%b valid=%b expected 1 0", end_pkt, bit_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid != 8 || bits_sh[7:0] !== pat) begin
      errors++; $display("FAIL basic_bits: got n=%0d bits=%b expected n=8 bits=%b", n_valid, bits_sh[7:0], pat);
    end
    checks++;
    if (n_start != 1 || n_end != 1 || n_err != 0) begin
      errors++; $display("FAIL basic_pulses: got start=%0d end=%0d err=%0d expected 1 1 0", n_start, n_end, n_err);
    end
  endtask

  task automatic test_stuffed_zero();
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);  // stuffed zero
    checks++;
    if (bit_valid !== 1'b0) begin
      errors++; $display("FAIL stuffed_drop: valid=%b expected 0", bit_valid);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bit_out !== 1'b1 || bit_valid !== 1'b0) begin
      errors++; $display("FAIL bit_out_hold: bit_out=%b valid=%b expected 1 0", bit_out, bit_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid != 7 || bits_sh[6:0] !== 7'b111_1111 || n_err != 0 || n_end != 1) begin
      errors++; $display("FAIL stuffed_bits: got n=%0d bits=%b err=%0d end=%0d expected 7 1111111 0 1",
                         n_valid, bits_sh[6:0], n_err, n_end);
    end
  endtask

  task automatic test_stuff_error();
    logic [3:0] tail;
    tail = 4'b0101;
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);  // seventh one
    checks++;
    if (stuff_err !== 1'b1 || bit_valid !== 1'b0) begin
      errors++; $display("FAIL stuff_err_pulse: err=%b valid=%b expected 1 0", stuff_err, bit_valid);
    end
    for (int i = 3; i >= 0; i--) drive(tail[i], 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (end_pkt !== 1'b1) begin
      errors++; $display("FAIL stuff_err_end: end=%b expected 1", end_pkt);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid != 6 || n_err != 1 || n_end != 1) begin
      errors++; $display("FAIL stuff_err_counts: got n=%0d err=%0d end=%0d expected 6 1 1", n_valid, n_err, n_end);
    end
  endtask

  task automatic test_end_on_seventh();
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid != 6 || n_err != 0 || n_end != 1) begin
      errors++; $display("FAIL end7_counts: got n=%0d err=%0d end=%0d expected 6 0 1", n_valid, n_err, n_end);
    end
    // The next packet must start counting ones from zero.
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid != 6 || bits_sh[5:0] !== 6'b11_1111 || n_err != 0) begin
      errors++; $display("FAIL end7_next_pkt: got n=%0d bits=%b err=%0d expected 6 111111 0", n_valid, bits_sh[5:0], n_err);
    end
  endtask

  task automatic test_abort();
    logic [4:0] pat;
    pat = 5'b10101;
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) drive(pat[i], 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bit_valid, start_pkt, end_pkt, stuff_err} !== 4'b0000) begin
      errors++; $display("FAIL abort_outputs: got %b expected 0000", {bit_valid, start_pkt, end_pkt, stuff_err});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid != 5 || n_end != 0 || bits_sh[4:0] !== pat) begin
      errors++; $display("FAIL abort_counts: got n=%0d end=%0d bits=%b expected 5 0 %b", n_valid, n_end, bits_sh[4:0], pat);
    end
    // Abort beats a simultaneous start.
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_start != 0 || n_valid != 0) begin
      errors++; $display("FAIL abort_vs_start: got start=%0d n=%0d expected 0 0", n_start, n_valid);
    end
    // A normal packet follows.
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_start != 1 || n_valid != 2 || bits_sh[1:0] !== 2'b01 || n_end != 1) begin
      errors++; $display("FAIL abort_recover: got start=%0d n=%0d bits=%b end=%0d expected 1 2 01 1",
                         n_start, n_valid, bits_sh[1:0], n_end);
    end
  endtask

  task automatic test_async_reset();
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
      errors++; $display("FAIL areset_pre: valid=%b bit=%b expected 1 1", bit_valid, bit_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bit_out, bit_valid, start_pkt, end_pkt, stuff_err} !== 5'b00000) begin
      errors++; $display("FAIL areset_outputs: got %b expected 00000",
                         {bit_out, bit_valid, start_pkt, end_pkt, stuff_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // There is no fresh start, so bits and end are ignored in IDLE.
    clear_obs();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid != 0 || n_end != 0 || n_start != 0) begin
      errors++; $display("FAIL areset_idle: got n=%0d end=%0d start=%0d expected 0 0 0", n_valid, n_end, n_start);
    end
    // A start pulse during ACTIVE is ignored and the bit is still data.
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (start_pkt !== 1'b0 || bit_valid !== 1'b1) begin
      errors++; $display("FAIL start_in_active: start=%b valid=%b expected 0 1", start_pkt, bit_valid);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_start != 1 || n_valid != 2 || n_end != 1) begin
      errors++; $display("FAIL start_in_active_counts: got start=%0d n=%0d end=%0d expected 1 2 1", n_start, n_valid, n_end);
    end
  endtask

  task automatic test_back_to_back();
    // Start and end together in IDLE: start wins.
    clear_obs();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (start_pkt !== 1'b1 || end_pkt !== 1'b0) begin
      errors++; $display("FAIL start_end_idle: start=%b end=%b expected 1 0", start_pkt, end_pkt);
    end
    // End during ALIGN closes an empty packet.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (end_pkt !== 1'b1 || bit_valid !== 1'b0) begin
      errors++; $display("FAIL end_in_align: end=%b valid=%b expected 1 0", end_pkt, bit_valid);
    end
    // A new start right after the end cycle.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_start != 2 || n_end != 2 || n_valid != 1 || bits_sh[0] !== 1'b1) begin
      errors++; $display("FAIL back_to_back: got start=%0d end=%0d n=%0d expected 2 2 1", n_start, n_end, n_valid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_obs();
    test_reset();
    test_basic();
    test_stuffed_zero();
    test_stuff_error();
    test_end_on_seventh();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_unstuff_rx.md
BIT_UNSTUFF_RX -- requirements
Module: bit_unstuff_rx

Interface
REQ-001 clk  input  1  receive bit clock; one serial bit per cycle.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 abort  input  1  synchronous receive abort; highest priority after reset.
REQ-004 s_in  input  1  NRZI-decoded serial bit from upstream decoder.
REQ-005 start_unstuffer  input  1  one-cycle packet-start pulse from upstream decoder.
REQ-006 end_unstuffer  input  1  one-cycle packet-end pulse from upstream decoder.
REQ-007 bit_out  output  1  unstuffed data bit; meaningful only when bit_valid=1.
REQ-008 bit_valid  output  1  bit_out carries a payload bit this cycle.
REQ-009 start_pkt  output  1  one-cycle pulse marking packet start to downstream packet receiver.
REQ-010 end_pkt  output  1  one-cycle pulse marking packet end.
REQ-011 stuff_err  output  1  one-cycle pulse on bit-stuffing violation (seven consecutive 1s).

Function
REQ-012 FSM states IDLE, ALIGN, ACTIVE, ERR; state register uses clk and asynchronous rst_n.
REQ-013 IDLE: start_unstuffer=1 -> ALIGN next cycle; end_unstuffer ignored in IDLE; s_in ignored.
REQ-014 ALIGN: lasts exactly one cycle; s_in ignored (upstream decoder ready cycle); -> ACTIVE, unless end_unstuffer=1 -> IDLE.
REQ-015 ACTIVE: s_in sampled every cycle; 3-bit ones counter cnt, range 0..6.
REQ-016 ACTIVE, cnt<6: bit accepted; cnt <= s_in ? cnt+1 : 0.
REQ-017 ACTIVE, cnt==6, s_in=0: stuffed bit dropped (no bit_valid); cnt <= 0.
REQ-018 ACTIVE, cnt==6, s_in=1: bit dropped; stuff_err pulse; cnt <= 0; -> ERR.
REQ-019 ERR: all s_in dropped; remains in ERR until end_unstuffer or abort.
REQ-020 ACTIVE or ERR with end_unstuffer=1: s_in that cycle is EOP, not data, dropped; cnt <= 0; -> IDLE.
REQ-021 start_unstuffer outside IDLE ignored; start_unstuffer and end_unstuffer together in IDLE -> start wins.
REQ-022 All outputs registered; latency one cycle from sampled s_in/pulse input to bit_out/bit_valid/start_pkt/end_pkt/stuff_err.
REQ-023 start_pkt pulses the cycle after start_unstuffer accepted in IDLE.
REQ-024 end_pkt pulses the cycle after end_unstuffer accepted in ALIGN, ACTIVE or ERR; therefore never coincides with the last bit_valid.
REQ-025 bit_out holds its last value when bit_valid=0.
REQ-026 cnt and ones history do not carry across packets; cleared on every IDLE entry.

Reset
REQ-027 rst_n=0 -> state IDLE, cnt=0, bit_out=0, bit_valid=0, start_pkt=0, end_pkt=0, stuff_err=0, immediately (asynchronous).
REQ-028 abort=1 in any state -> IDLE and cnt=0 next cycle; bit_valid, start_pkt, end_pkt, stuff_err all 0 next cycle; no end_pkt for aborted packet.
REQ-029 abort and start_unstuffer together -> abort wins; packet not started.
REQ-030 rst_n deassertion mid-packet -> block waits in IDLE for a fresh start_unstuffer.

Verification
REQ-031 start pulse, skip 1, then bits 1011_0010, end -> start_pkt at T+1; 8 bit_valid pulses with 1,0,1,1,0,0,1,0; end_pkt one cycle after end; stuff_err never.
REQ-032 Bits 111111 0 1 -> 6 valid 1s, stuffed 0 dropped, next 1 valid; 7 valid bits total; stuff_err=0.
REQ-033 Bits 1111111 then 0101, end -> 6 valid 1s, stuff_err one pulse on 7th, no further bit_valid, end_pkt still pulses.
REQ-034 Bits 111111 then end_unstuffer on 7th cycle -> 6 valid bits, no stuff_err, end_pkt pulse; next packet starting 1 counts from cnt=0.
REQ-035 abort after 5 valid bits -> no bit_valid/end_pkt afterwards; subsequent start_unstuffer produces normal packet.
REQ-036 rst_n low mid-ACTIVE with bit_valid=1 -> all outputs 0 same cycle; start_unstuffer during ACTIVE and end_unstuffer during IDLE ignored.
